dead_time_inserter: RTL and testbench

- Three-phase gate conditioning stage placed directly downstream of the modulator. Its inputs are the modulator's six raw gate requests (g1/g2 per phase A, B, C).
- Guarantees that the two gates of a leg are never high together. Inserts a programmable dead time at every leg commutation.
- Latches a sticky fault and forces all gates low whenever the modulator requests both gates of one leg at once.
- Outputs drive the gate-driver pins.

---
 rtl/lgbs_gate_pkg.sv | 32 +++
 rtl/dead_time_phase.sv | 122 ++++++++++++
 rtl/dead_time_inserter.sv | 109 ++++++++++
 tb/tb_dead_time_inserter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lgbs_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lgbs_gate_pkg
//  Description : Shared definitions for the three-phase dead-time inserter:
//                per-leg state encoding, gate request encoding and the
//                default dead-time length.
//  Revision    : 1.0 - initial release
// ============================================================================
package lgbs_gate_pkg;

    // Default dead time: 24 cycles = 1 us at 24 MHz.
    localparam int unsigned c_DEAD_CYCLES_DEF = 24;

    // Per-leg state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;  // both low, dead time satisfied
    localparam logic [1:0] c_ST_DEAD = 2'd1;  // both low, counting
    localparam logic [1:0] c_ST_ON1  = 2'd2;  // g1 high
    localparam logic [1:0] c_ST_ON2  = 2'd3;  // g2 high

    // Request encoding; identical to the raw {g1, g2} pair.
    localparam logic [1:0] c_REQ_OFF     = 2'b00;
    localparam logic [1:0] c_REQ2        = 2'b01;
    localparam logic [1:0] c_REQ1        = 2'b10;
    localparam logic [1:0] c_REQ_ILLEGAL = 2'b11;

    // True when a leg asks for both gates at once.
    function automatic logic f_is_illegal(input logic [1:0] i_pair);
        return (i_pair == c_REQ_ILLEGAL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dead_time_phase.sv
`default_nettype none
// ============================================================================
//  Module      : dead_time_phase
//  Description : One inverter leg: state machine plus dead-time counter.
//                Guarantees at least DEAD_CYCLES cycles with both gates low
//                between any turn-off and the next turn-on. Gate outputs are
//                registered alongside the state.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_force_off     - hold leg in DEAD with counter reloaded
//                i_req[1:0]      - registered request pair {g1, g2}
//                o_g1, o_g2      - registered gate drives
//                o_dead          - leg currently in DEAD
//  Revision    : 1.0 - initial release
// ============================================================================
module dead_time_phase
    import lgbs_gate_pkg::*;
#(
    parameter int DEAD_CYCLES = c_DEAD_CYCLES_DEF,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_force_off,
    input  logic [1:0] i_req,
    output logic       o_g1,
    output logic       o_g2,
    output logic       o_dead
);

    // DEAD lasts load+1 cycles: the count==0 cycle is the last low one.
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_g1;
    logic             r_g2;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_g1_nxt;
    logic             w_g2_nxt;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_DEAD;
            r_cnt   <= c_CNT_LOAD;
            r_g1    <= 1'b0;
            r_g2    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_g1    <= w_g1_nxt;
            r_g2    <= w_g2_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_force_off) begin
            // Continuous reload keeps a full dead time pending after release.
            w_state_nxt = c_ST_DEAD;
            w_cnt_nxt   = c_CNT_LOAD;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_req == c_REQ1) begin
                        w_state_nxt = c_ST_ON1;
                    end else if (i_req == c_REQ2) begin
                        w_state_nxt = c_ST_ON2;
                    end
                end
                c_ST_ON1: begin
                    if (i_req != c_REQ1) begin
                        w_state_nxt = c_ST_DEAD;
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
                c_ST_ON2: begin
                    if (i_req != c_REQ2) begin
                        w_state_nxt = c_ST_DEAD;
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
                c_ST_DEAD: begin
                    // Requests are not looked at until the count expires, so a
                    // pulse that returns to the old value is simply absorbed.
                    if (r_cnt == '0) begin
                        if (i_req == c_REQ1) begin
                            w_state_nxt = c_ST_ON1;
                        end else if (i_req == c_REQ2) begin
                            w_state_nxt = c_ST_ON2;
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_DEAD;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            endcase
        end
    end

    // ---------------- output logic ----------------
    // Gates are decoded from the next state so they flop on the same edge.
    always_comb begin
        w_g1_nxt = (w_state_nxt == c_ST_ON1);
        w_g2_nxt = (w_state_nxt == c_ST_ON2);
    end

    assign o_g1   = r_g1;
    assign o_g2   = r_g2;
    assign o_dead = (r_state == c_ST_DEAD);

endmodule
`default_nettype wire

// File: rtl/dead_time_inserter.sv
`default_nettype none
// ============================================================================
//  Module      : dead_time_inserter
//  Description : Three-phase gate conditioning stage. Registers the six raw
//                modulator requests, runs one dead-time leg per phase, and
//                latches a sticky fault (all gates off) whenever a leg asks
//                for both gates at once.
//  Ports       : clk, reset             - clock, synchronous active-high reset
//                enable                 - 0 forces all gates low
//                g1_x_in, g2_x_in       - raw requests, x = a/b/c
//                g1_x, g2_x             - registered protected gate drives
//                fault                  - sticky illegal-request flag
//                busy                   - any leg in DEAD
//  Revision    : 1.0 - initial release
// ============================================================================
module dead_time_inserter
    import lgbs_gate_pkg::*;
#(
    parameter int DEAD_CYCLES = c_DEAD_CYCLES_DEF,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic g1_a_in,
    input  logic g2_a_in,
    input  logic g1_b_in,
    input  logic g2_b_in,
    input  logic g1_c_in,
    input  logic g2_c_in,
    output logic g1_a,
    output logic g2_a,
    output logic g1_b,
    output logic g2_b,
    output logic g1_c,
    output logic g2_c,
    output logic fault,
    output logic busy
);

    localparam int c_NUM_PH = 3;

    // Packed as {a, b, c} pairs, g1 in the upper bit of each pair.
    logic [2*c_NUM_PH-1:0] r_in;
    logic                  r_fault;

    logic [c_NUM_PH-1:0]   w_illegal;
    logic                  w_illegal_any;
    logic                  w_force_off;
    logic [c_NUM_PH-1:0]   w_g1;
    logic [c_NUM_PH-1:0]   w_g2;
    logic [c_NUM_PH-1:0]   w_dead;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in <= '0;
        end else begin
            r_in <= {g1_a_in, g2_a_in, g1_b_in, g2_b_in, g1_c_in, g2_c_in};
        end
    end

    assign w_illegal_any = |w_illegal;

    // Fault is set on the same edge the legs see the illegal request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_illegal_any) begin
            r_fault <= 1'b1;
        end
    end

    // The live illegal decode is included so the offending edge already
    // shuts the gates, not the one after it.
    assign w_force_off = !enable | r_fault | w_illegal_any;

    genvar gi;
    generate
        for (gi = 0; gi < c_NUM_PH; gi++) begin : g_phase
            logic [1:0] w_pair;
            assign w_pair        = r_in[2*(c_NUM_PH-1-gi) +: 2];
            assign w_illegal[gi] = f_is_illegal(w_pair);

            dead_time_phase #(
                .DEAD_CYCLES (DEAD_CYCLES),
                .CNT_W       (CNT_W)
            ) u_phase (
                .clk         (clk),
                .rst         (reset),
                .i_force_off (w_force_off),
                .i_req       (w_pair),
                .o_g1        (w_g1[gi]),
                .o_g2        (w_g2[gi]),
                .o_dead      (w_dead[gi])
            );
        end
    endgenerate

    assign g1_a  = w_g1[0];
    assign g2_a  = w_g2[0];
    assign g1_b  = w_g1[1];
    assign g2_b  = w_g2[1];
    assign g1_c  = w_g1[2];
    assign g2_c  = w_g2[2];
    assign fault = r_fault;
    assign busy  = |w_dead;

endmodule
`default_nettype wire

// File: tb/tb_dead_time_inserter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dead_time_inserter
//  Description : Self-checking bench for dead_time_inserter, DEAD_CYCLES=4.
//                Vector/output bit order: {g1_a,g2_a,g1_b,g2_b,g1_c,g2_c}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dead_time_inserter;

    logic clk;
    logic reset;
    logic enable;
    logic [5:0] r_drv;
    logic g1_a, g2_a, g1_b, g2_b, g1_c, g2_c;
    logic fault, busy;
    logic [5:0] w_outs;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [5:0] in;
        logic [5:0] out;
        logic       flt;
        logic       bsy;
    } vec_t;

    vec_t tv[$];

    dead_time_inserter #(
        .DEAD_CYCLES (4),
        .CNT_W       (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .g1_a_in (r_drv[5]),
        .g2_a_in (r_drv[4]),
        .g1_b_in (r_drv[3]),
        .g2_b_in (r_drv[2]),
        .g1_c_in (r_drv[1]),
        .g2_c_in (r_drv[0]),
        .g1_a    (g1_a),
        .g2_a    (g2_a),
        .g1_b    (g1_b),
        .g2_b    (g2_b),
        .g1_c    (g1_c),
        .g2_c    (g2_c),
        .fault   (fault),
        .busy    (busy)
    );

    assign w_outs = {g1_a, g2_a, g1_b, g2_b, g1_c, g2_c};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk6(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic addv(input logic r, input logic e, input logic [5:0] i,
                        input logic [5:0] o, input logic f, input logic b);
        vec_t v;
        v.rst = r; v.en = e; v.in = i; v.out = o; v.flt = f; v.bsy = b;
        tv.push_back(v);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        r_drv  = '0;

        // ---- table: reset release, commutation, glitch, short pulse ----
        //   rst   en    inputs     outputs   flt   busy
        addv(1'b1, 1'b1, 6'b100000, 6'b000000, 1'b0, 1'b1); // 0 reset
        addv(1'b0, 1'b1, 6'b100000, 6'b000000, 1'b0, 1'b1); // 1 dead
        addv(1'b0, 1'b1, 6'b100000, 6'b000000, 1'b0, 1'b1); // 2
        addv(1'b0, 1'b1, 6'b100000, 6'b000000, 1'b0, 1'b1); // 3
        addv(1'b0, 1'b1, 6'b100000, 6'b100000, 1'b0, 1'b0); // 4 g1_a rises
        addv(1'b0, 1'b1, 6'b100000, 6'b100000, 1'b0, 1'b0); // 5
        addv(1'b0, 1'b1, 6'b010000, 6'b100000, 1'b0, 1'b0); // 6 E0
        addv(1'b0, 1'b1, 6'b010000, 6'b000000, 1'b0, 1'b1); // 7 E1 g1 falls
        addv(1'b0, 1'b1, 6'b010000, 6'b000000, 1'b0, 1'b1); // 8
        addv(1'b0, 1'b1, 6'b010000, 6'b000000, 1'b0, 1'b1); // 9
        addv(1'b0, 1'b1, 6'b010000, 6'b000000, 1'b0, 1'b1); // 10 E4
        addv(1'b0, 1'b1, 6'b010000, 6'b010000, 1'b0, 1'b0); // 11 E5 g2 rises
        addv(1'b0, 1'b1, 6'b100000, 6'b010000, 1'b0, 1'b0); // 12 back to 10
        addv(1'b0, 1'b1, 6'b100000, 6'b000000, 1'b0, 1'b1); // 13
        addv(1'b0, 1'b1, 6'b100000, 6'b000000, 1'b0, 1'b1); // 14
        addv(1'b0, 1'b1, 6'b100000, 6'b000000, 1'b0, 1'b1); // 15
        addv(1'b0, 1'b1, 6'b100000, 6'b000000, 1'b0, 1'b1); // 16
        addv(1'b0, 1'b1, 6'b100000, 6'b100000, 1'b0, 1'b0); // 17 ON1
        addv(1'b0, 1'b1, 6'b010000, 6'b100000, 1'b0, 1'b0); // 18 glitch 01
        addv(1'b0, 1'b1, 6'b010000, 6'b000000, 1'b0, 1'b1); // 19 glitch 01
        addv(1'b0, 1'b1, 6'b100000, 6'b000000, 1'b0, 1'b1); // 20 back to 10
        addv(1'b0, 1'b1, 6'b100000, 6'b000000, 1'b0, 1'b1); // 21
        addv(1'b0, 1'b1, 6'b100000, 6'b000000, 1'b0, 1'b1); // 22
        addv(1'b0, 1'b1, 6'b100000, 6'b100000, 1'b0, 1'b0); // 23 g1_a back
        addv(1'b0, 1'b1, 6'b101000, 6'b100000, 1'b0, 1'b0); // 24 B 1-cycle pulse
        addv(1'b0, 1'b1, 6'b100000, 6'b101000, 1'b0, 1'b0); // 25 g1_b on
        addv(1'b0, 1'b1, 6'b100000, 6'b100000, 1'b0, 1'b1); // 26 B dead
        addv(1'b0, 1'b1, 6'b100000, 6'b100000, 1'b0, 1'b1); // 27
        addv(1'b0, 1'b1, 6'b100000, 6'b100000, 1'b0, 1'b1); // 28
        addv(1'b0, 1'b1, 6'b100000, 6'b100000, 1'b0, 1'b1); // 29
        addv(1'b0, 1'b1, 6'b100000, 6'b100000, 1'b0, 1'b0); // 30 B idle

        for (int i = 0; i < tv.size(); i++) begin
            reset  = tv[i].rst;
            enable = tv[i].en;
            r_drv  = tv[i].in;
            step();
            chk6($sformatf("vec%0d_gates", i), w_outs, tv[i].out);
            chk1($sformatf("vec%0d_fault", i), fault, tv[i].flt);
            chk1($sformatf("vec%0d_busy", i), busy, tv[i].bsy);
        end

        // ---- illegal request on phase B for one cycle ----
        r_drv = 6'b101100;
        step();
        chk6("flt_pre_gates", w_outs, 6'b100000);
        chk1("flt_pre_fault", fault, 1'b0);
        r_drv = 6'b100000;
        step();
        chk6("flt_set_gates", w_outs, 6'b000000);
        chk1("flt_set_fault", fault, 1'b1);
        for (int i = 0; i < 50; i++) begin
            r_drv = (i % 2 == 0) ? 6'b100110 : 6'b011001;
            step();
            chk6($sformatf("flt_hold%0d_gates", i), w_outs, 6'b000000);
            chk1($sformatf("flt_hold%0d_fault", i), fault, 1'b1);
        end

        // ---- reset clears fault; all phases turn on ----
        r_drv = 6'b100110;
        reset = 1'b1;
        step();
        chk1("rst_clr_fault", fault, 1'b0);
        chk6("rst_clr_gates", w_outs, 6'b000000);
        chk1("rst_clr_busy", busy, 1'b1);
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk6($sformatf("rst_dead%0d_gates", i), w_outs, 6'b000000);
        end
        step();
        chk6("all_on_gates", w_outs, 6'b100110);
        chk1("all_on_busy", busy, 1'b0);

        // ---- enable low for 10 cycles ----
        enable = 1'b0;
        step();
        step();
        chk6("en_off_2edges", w_outs, 6'b000000);
        for (int i = 3; i <= 10; i++) begin
            step();
            chk6($sformatf("en_off%0d_gates", i), w_outs, 6'b000000);
        end
        chk1("en_off_busy", busy, 1'b1);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk6($sformatf("en_back%0d_gates", i), w_outs, 6'b000000);
        end
        step();
        chk6("en_back_on_gates", w_outs, 6'b100110);

        // ---- reset during DEAD on phase C ----
        r_drv = 6'b100101;
        step();                                    // E0
        chk6("c_e0_gates", w_outs, 6'b100110);
        step();                                    // E1: g1_c falls
        chk6("c_e1_gates", w_outs, 6'b100100);
        chk1("c_e1_busy", busy, 1'b1);
        step();                                    // E2
        chk6("c_e2_gates", w_outs, 6'b100100);
        reset = 1'b1;
        step();                                    // E3 = R
        chk6("c_rst_gates", w_outs, 6'b000000);
        reset = 1'b0;
        step();                                    // R+1
        chk6("c_r1_gates", w_outs, 6'b000000);
        step();                                    // R+2: original expiry
        chk6("c_orig_expiry_gates", w_outs, 6'b000000);
        step();                                    // R+3
        chk6("c_r3_gates", w_outs, 6'b000000);
        step();                                    // R+4: restarted expiry
        chk6("c_r4_gates", w_outs, 6'b100101);
        chk1("c_r4_fault", fault, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
